// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing controller: ALUCtrl codes, FSM states, default width.
package alu_pkg;

    localparam int DATA_W_DEF = 64;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_supported(input logic [3:0] code);
        return (code == ALU_AND) || (code == ALU_OR) || (code == ALU_ADD) ||
               (code == ALU_SUB) || (code == ALU_PASSB);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
// Produces a one-hot grant and its encoded index; the rotation pointer lives in the caller.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    int   cand;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU among N_REQ requesters: accept -> EXEC (1 cycle) -> RESP held until resp_ready.
// Optional OPCODE_CHECK_EN: unsupported opcodes are forced to PassB of zero and flagged on resp_err.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    CLK,
    input  logic                    Resetb,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*4-1:0]      req_ctrl,
    output logic [N_REQ-1:0]        resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    resp_zero,
    output logic                    resp_err,
    output logic [DATA_W-1:0]       alu_busa,
    output logic [DATA_W-1:0]       alu_busb,
    output logic [3:0]              alu_ctrl,
    input  logic [DATA_W-1:0]       alu_busw,
    input  logic                    alu_zero
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [3:0]         op_ctrl;

    logic [N_REQ-1:0]   grant;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   ptr_next;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic [3:0]         sel_ctrl;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = (state == IDLE) ? grant : '0;
    assign sel_a     = req_a[gidx*DATA_W +: DATA_W];
    assign sel_b     = req_b[gidx*DATA_W +: DATA_W];
    assign sel_ctrl  = req_ctrl[gidx*4 +: 4];
    assign ptr_next  = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    assign alu_busa = op_a;
    assign alu_busb = op_b;
    assign alu_ctrl = op_ctrl;

`ifdef OPCODE_CHECK_EN
    logic op_err;
    logic err_q;
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge Resetb) begin
        if (!Resetb) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_ctrl    <= ALU_PASSB;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
`ifdef OPCODE_CHECK_EN
            op_err     <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        op_ctrl <= sel_ctrl;
`ifdef OPCODE_CHECK_EN
                        op_err  <= 1'b0;
                        // PassB of zero makes the ALU itself yield data 0 / zero 1.
                        if (!is_supported(sel_ctrl)) begin
                            op_b    <= '0;
                            op_ctrl <= ALU_PASSB;
                            op_err  <= 1'b1;
                        end
`endif
                        owner   <= gidx;
                        ptr     <= ptr_next;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data  <= alu_busw;
                    resp_zero  <= alu_zero;
`ifdef OPCODE_CHECK_EN
                    err_q      <= op_err;
`endif
                    resp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << owner;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU on the shared bus.
module tb_alu_share_ctrl;

    logic         CLK;
    logic         Resetb;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [7:0]   req_ctrl;
    logic [1:0]   resp_valid;
    logic         resp_ready;
    logic [63:0]  resp_data;
    logic         resp_zero;
    logic         resp_err;
    logic [63:0]  alu_busa;
    logic [63:0]  alu_busb;
    logic [3:0]   alu_ctrl;
    logic [63:0]  alu_busw;
    logic         alu_zero;

    int passed = 0;
    int total  = 0;

    alu_share_ctrl #(.N_REQ(2), .DATA_W(64)) dut (
        .CLK        (CLK),
        .Resetb     (Resetb),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_err   (resp_err),
        .alu_busa   (alu_busa),
        .alu_busb   (alu_busb),
        .alu_ctrl   (alu_ctrl),
        .alu_busw   (alu_busw),
        .alu_zero   (alu_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in ALU; undefined codes give a^b so pass-through is distinguishable.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_busw = alu_busa & alu_busb;
            4'b0001: alu_busw = alu_busa | alu_busb;
            4'b0010: alu_busw = alu_busa + alu_busb;
            4'b0110: alu_busw = alu_busa - alu_busb;
            4'b0111: alu_busw = alu_busb;
            default: alu_busw = alu_busa ^ alu_busb;
        endcase
        alu_zero = (alu_busw == 64'd0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        req_a[i*64 +: 64]  = a;
        req_b[i*64 +: 64]  = b;
        req_ctrl[i*4 +: 4] = c;
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
    endtask

    initial begin
        Resetb     = 1'b0;
        req_valid  = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_ctrl   = '0;
        resp_ready = 1'b0;
        repeat (2) cyc();
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_alu_ctrl", 64'(alu_ctrl), 64'h7);
        check("rst_alu_busa", alu_busa, 64'h0);
        check("rst_resp_data", resp_data, 64'h0);
        check("rst_resp_err", 64'(resp_err), 64'h0);
        Resetb = 1'b1;
        cyc();

        // Single request: ADD 5+7
        set_req(0, 4'b0010, 64'd5, 64'd7);
        req_valid = 2'b01;
        #1 check("single_ready", 64'(req_ready), 64'h1);
        cyc();
        req_valid = 2'b00;
        check("single_exec_valid", 64'(resp_valid), 64'h0);
        check("single_exec_busa", alu_busa, 64'd5);
        cyc();
        check("single_resp_valid", 64'(resp_valid), 64'h1);
        check("single_resp_data", resp_data, 64'd12);
        check("single_resp_zero", 64'(resp_zero), 64'h0);
        release_resp();
        check("single_done_valid", 64'(resp_valid), 64'h0);

        // Both valid straight from reset: req0 wins first
        Resetb = 1'b0;
        cyc();
        Resetb = 1'b1;
        set_req(0, 4'b0110, 64'd9, 64'd9);
        set_req(1, 4'b0001, 64'hF0, 64'h0F);
        req_valid = 2'b11;
        #1 check("both_first_grant", 64'(req_ready), 64'h1);
        cyc();
        req_valid = 2'b10;
        cyc();
        check("both_sub_valid", 64'(resp_valid), 64'h1);
        check("both_sub_data", resp_data, 64'h0);
        check("both_sub_zero", 64'(resp_zero), 64'h1);
        release_resp();
        check("both_second_grant", 64'(req_ready), 64'h2);
        cyc();
        req_valid = 2'b00;
        cyc();
        check("both_or_valid", 64'(resp_valid), 64'h2);
        check("both_or_data", resp_data, 64'hFF);
        check("both_or_zero", 64'(resp_zero), 64'h0);
        release_resp();

        // Backpressure: hold RESP for 5 cycles with requests pending
        set_req(1, 4'b0010, 64'd1, 64'd2);
        req_valid = 2'b10;
        cyc();
        req_valid = 2'b00;
        cyc();
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(resp_valid), 64'h2);
            check("bp_data", resp_data, 64'd3);
            check("bp_ready", 64'(req_ready), 64'h0);
            cyc();
        end
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        check("bp_released", 64'(resp_valid), 64'h0);
        req_valid = 2'b01;
        #1 check("bp_idle_ready", 64'(req_ready), 64'h1);
        req_valid = 2'b00;

        // Fairness: both held valid for 6 operations
        set_req(0, 4'b0010, 64'd10, 64'd1);
        set_req(1, 4'b0010, 64'd20, 64'd2);
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1 check("fair_grant", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            cyc();
            cyc();
            check("fair_resp_valid", 64'(resp_valid), (i % 2 == 0) ? 64'h1 : 64'h2);
            check("fair_resp_data", resp_data, (i % 2 == 0) ? 64'd11 : 64'd22);
            release_resp();
        end
        req_valid = 2'b00;

        // Reset during EXEC discards the op and clears ptr
        set_req(0, 4'b0010, 64'd4, 64'd4);
        req_valid = 2'b01;
        cyc();
        req_valid = 2'b00;
        check("rex_in_exec_ctrl", 64'(alu_ctrl), 64'h2);
        Resetb = 1'b0;
        #1 check("rex_ctrl_reset", 64'(alu_ctrl), 64'h7);
        check("rex_busa_reset", alu_busa, 64'h0);
        cyc();
        Resetb = 1'b1;
        check("rex_no_resp0", 64'(resp_valid), 64'h0);
        cyc();
        check("rex_no_resp1", 64'(resp_valid), 64'h0);
        req_valid = 2'b11;
        #1 check("rex_ptr_zero", 64'(req_ready), 64'h1);
        set_req(1, 4'b0000, 64'hFF, 64'h0F);
        req_valid = 2'b10;
        #1 check("rex_req1_ready", 64'(req_ready), 64'h2);
        cyc();
        req_valid = 2'b00;
        cyc();
        check("rex_and_valid", 64'(resp_valid), 64'h2);
        check("rex_and_data", resp_data, 64'h0F);
        release_resp();

        // Unsupported opcode 1111 with a=3 b=5
        set_req(0, 4'b1111, 64'd3, 64'd5);
        req_valid = 2'b01;
        cyc();
        req_valid = 2'b00;
`ifdef OPCODE_CHECK_EN
        check("bad_exec_ctrl", 64'(alu_ctrl), 64'h7);
        cyc();
        check("bad_data", resp_data, 64'h0);
        check("bad_zero", 64'(resp_zero), 64'h1);
        check("bad_err", 64'(resp_err), 64'h1);
`else
        check("bad_exec_ctrl", 64'(alu_ctrl), 64'hF);
        cyc();
        check("bad_data", resp_data, 64'h6);
        check("bad_zero", 64'(resp_zero), 64'h0);
        check("bad_err", 64'(resp_err), 64'h0);
`endif
        check("bad_valid", 64'(resp_valid), 64'h1);
        release_resp();
        check("bad_done", 64'(resp_valid), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
